instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE/REQ/WAIT request FSM feeding one output slot.
// Optional one-entry skid buffer behind macro FETCH_SKID_EN (off by default).
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic        id_ready,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        im_stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        deliver;
    logic        fire;

    // A return counts only in WAIT, so stray or post-reset rvalids are ignored.
    assign deliver = (state_q == ST_WAIT) & im_rvalid & ~kill_q & ~flush;
    assign fire    = im_req & im_gnt;
    assign im_addr = pc_in;
    assign im_stall = (state_q == ST_IDLE) | (~flush & ~deliver);

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

`ifdef FETCH_SKID_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    assign im_req = (state_q == ST_REQ) & ~skid_valid_q & ~flush;

    always_comb begin
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        if (flush) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (deliver) begin
            if (if_valid_q & ~id_ready) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = req_pc_q;
                skid_inst_d  = im_rdata;
            end else begin
                if_valid_d = 1'b1;
                if_pc_d    = req_pc_q;
                if_inst_d  = im_rdata;
            end
        end else if (id_ready) begin
            if (skid_valid_q) begin
                if_valid_d   = 1'b1;
                if_pc_d      = skid_pc_q;
                if_inst_d    = skid_inst_q;
                skid_valid_d = 1'b0;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= NOP;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end
`else
    // Requests only go out when the slot will be free, so a return always has room.
    assign im_req = (state_q == ST_REQ) & (~if_valid_q | id_ready) & ~flush;

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (deliver) begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_inst_d  = im_rdata;
        end else if (flush | id_ready) begin
            if_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        req_pc_d = req_pc_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (fire) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_in;
                end
            end
            ST_WAIT: begin
                // Flush before the data returns leaves a kill mark for the stale word.
                if (im_rvalid) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kill_q     <= 1'b0;
            req_pc_q   <= 32'h0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_inst_q  <= NOP;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build, no skid buffer).
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        flush;
    logic        id_ready;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        im_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .flush     (flush),
        .id_ready  (id_ready),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_gnt    (im_gnt),
        .im_rvalid (im_rvalid),
        .im_rdata  (im_rdata),
        .im_stall  (im_stall),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; id_ready = 1'b0; pc_in = 32'h0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'h0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0000_0013);
        chk("rst_im_req", {31'h0, im_req}, 32'h0);
        chk("rst_im_stall", {31'h0, im_stall}, 32'h1);

        // Release reset: IDLE for one cycle
        @(negedge clk); reset = 1'b1; id_ready = 1'b1; im_gnt = 1'b1; pc_in = 32'h0; #1;
        chk("idle_im_req", {31'h0, im_req}, 32'h0);
        chk("idle_im_stall", {31'h0, im_stall}, 32'h1);

        // First request at 0x0, granted
        @(negedge clk); #1;
        chk("req0_im_req", {31'h0, im_req}, 32'h1);
        chk("req0_im_addr", im_addr, 32'h0);
        chk("req0_im_stall", {31'h0, im_stall}, 32'h1);
        chk("req0_if_valid", {31'h0, if_valid}, 32'h0);

        // Return one cycle after grant
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h0050_0093; #1;
        chk("wait0_im_req", {31'h0, im_req}, 32'h0);
        chk("ret0_im_stall", {31'h0, im_stall}, 32'h0);

        @(negedge clk); im_rvalid = 1'b0; pc_in = 32'h4; #1;
        chk("out0_if_valid", {31'h0, if_valid}, 32'h1);
        chk("out0_if_pc", if_pc, 32'h0);
        chk("out0_if_inst", if_inst, 32'h0050_0093);
        chk("out0_im_stall", {31'h0, im_stall}, 32'h1);
        chk("req4_im_req", {31'h0, im_req}, 32'h1);
        chk("req4_im_addr", im_addr, 32'h4);

        // Return for 0x4 while decode stops accepting
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h00A0_0113; id_ready = 1'b0; #1;
        chk("ret4_im_stall", {31'h0, im_stall}, 32'h0);
        chk("ret4_if_valid", {31'h0, if_valid}, 32'h0);

        // Held for 5 cycles; a stray rvalid in REQ is ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            im_rvalid = (i == 1);
            im_rdata  = (i == 1) ? 32'hBADB_AD00 : 32'h00A0_0113;
            pc_in = 32'h8; #1;
            chk("hold_if_valid", {31'h0, if_valid}, 32'h1);
            chk("hold_if_pc", if_pc, 32'h4);
            chk("hold_if_inst", if_inst, 32'h00A0_0113);
            chk("hold_im_req", {31'h0, im_req}, 32'h0);
            chk("hold_im_stall", {31'h0, im_stall}, 32'h1);
        end

        // Grant withheld for 3 cycles; address tracks pc_in
        @(negedge clk); im_rvalid = 1'b0; id_ready = 1'b1; im_gnt = 1'b0; #1;
        chk("nogrant0_im_req", {31'h0, im_req}, 32'h1);
        chk("nogrant0_im_addr", im_addr, 32'h8);
        chk("nogrant0_im_stall", {31'h0, im_stall}, 32'h1);
        @(negedge clk); pc_in = 32'h20; #1;
        chk("nogrant1_im_req", {31'h0, im_req}, 32'h1);
        chk("nogrant1_im_addr", im_addr, 32'h20);
        chk("nogrant1_im_stall", {31'h0, im_stall}, 32'h1);
        chk("nogrant1_if_valid", {31'h0, if_valid}, 32'h0);
        @(negedge clk); pc_in = 32'h24; #1;
        chk("nogrant2_im_req", {31'h0, im_req}, 32'h1);
        chk("nogrant2_im_addr", im_addr, 32'h24);
        chk("nogrant2_im_stall", {31'h0, im_stall}, 32'h1);
        @(negedge clk); im_gnt = 1'b1; #1;
        chk("grant24_im_req", {31'h0, im_req}, 32'h1);

        // Flush in WAIT, stale data two cycles later
        @(negedge clk); flush = 1'b1; pc_in = 32'h100; #1;
        chk("flushw_im_req", {31'h0, im_req}, 32'h0);
        chk("flushw_im_stall", {31'h0, im_stall}, 32'h0);
        @(negedge clk); flush = 1'b0; #1;
        chk("killw_im_req", {31'h0, im_req}, 32'h0);
        chk("killw_im_stall", {31'h0, im_stall}, 32'h1);
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF; #1;
        chk("killret_im_stall", {31'h0, im_stall}, 32'h1);
        chk("killret_im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk); im_rvalid = 1'b0; #1;
        chk("killed_if_valid", {31'h0, if_valid}, 32'h0);
        chk("killed_if_inst", if_inst, 32'h00A0_0113);
        chk("redir_im_req", {31'h0, im_req}, 32'h1);
        chk("redir_im_addr", im_addr, 32'h100);

        // Deliver 0x100, then flush clears if_valid
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h0000_0513; id_ready = 1'b0; #1;
        chk("ret100_im_stall", {31'h0, im_stall}, 32'h0);
        @(negedge clk); im_rvalid = 1'b0; flush = 1'b1; pc_in = 32'h200; #1;
        chk("out100_if_valid", {31'h0, if_valid}, 32'h1);
        chk("out100_if_pc", if_pc, 32'h100);
        chk("out100_if_inst", if_inst, 32'h0000_0513);
        chk("flushr_im_req", {31'h0, im_req}, 32'h0);
        chk("flushr_im_stall", {31'h0, im_stall}, 32'h0);
        @(negedge clk); flush = 1'b0; id_ready = 1'b1; #1;
        chk("flushed_if_valid", {31'h0, if_valid}, 32'h0);
        chk("flushed_if_inst", if_inst, 32'h0000_0513);
        chk("req200_im_req", {31'h0, im_req}, 32'h1);
        chk("req200_im_addr", im_addr, 32'h200);

        // Reset pulsed mid-cycle while in WAIT
        @(negedge clk); #1;
        chk("wait200_im_req", {31'h0, im_req}, 32'h0);
        chk("wait200_im_stall", {31'h0, im_stall}, 32'h1);
        #2; reset = 1'b0; #1;
        chk("arst_im_req", {31'h0, im_req}, 32'h0);
        chk("arst_im_stall", {31'h0, im_stall}, 32'h1);
        chk("arst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_inst", if_inst, 32'h0000_0013);

        // Late rvalid after reset release is ignored
        @(negedge clk); reset = 1'b1; im_rvalid = 1'b1; im_rdata = 32'hCAFE_F00D;
        pc_in = 32'h0; im_gnt = 1'b0; #1;
        chk("late_im_stall", {31'h0, im_stall}, 32'h1);
        chk("late_im_req", {31'h0, im_req}, 32'h0);
        @(negedge clk); im_rvalid = 1'b0; #1;
        chk("late_if_valid", {31'h0, if_valid}, 32'h0);
        chk("late_if_inst", if_inst, 32'h0000_0013);
        chk("post_im_req", {31'h0, im_req}, 32'h1);
        chk("post_im_addr", im_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
